// File: rtl/aes128_pkg.sv
// Shared AES-128 types, round constants and GF(2^8)/key-schedule helpers
// used by the round controller and its combinational round datapath.
package aes128_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam int NUM_ROUNDS = 10;

  // Indexed by round number; entries 0 and 11..15 are never used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes128_round_step.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Byte i of the block lives at [127-8i -: 8], column-major.
module aes128_round_step
  import aes128_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_mix,
  output logic [127:0] o_state
);

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_sub
    assign w_sb[127-8*g -: 8] = sbox(i_state[127-8*g -: 8]);
  end

  // Row r of column c takes the byte from column (c + r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign w_mc[127-32*c -: 32] = i_mix ? mix_column(w_sr[127-32*c -: 32])
                                        : w_sr[127-32*c -: 32];
  end

  assign o_state = w_mc ^ i_rk;

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per cycle, key schedule
// expanded on the fly. Build option AES_ABORT_EN adds an abort input.
module aes128_round_ctrl
  import aes128_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_ABORT_EN
  input  logic         i_abort,
`endif
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_pt,
  input  logic [127:0] i_in_key,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_ct,
  output logic         o_busy
);

  aes_state_e   r_fsm;
  aes_state_e   w_fsm_nxt;
  logic [3:0]   r_round;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic         r_out_valid;
  logic         r_busy;
  logic [127:0] w_nk;
  logic [127:0] w_step;
  logic         w_in_ready;
  logic         w_accept;
  logic         w_abort;

`ifdef AES_ABORT_EN
  assign w_abort = i_abort & (r_fsm != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_nk = key_expand(r_rk, RCON[r_round]);

  aes128_round_step u_round_step (
    .i_state (r_state),
    .i_rk    (w_nk),
    .i_mix   (r_round != 4'd10),
    .o_state (w_step)
  );

  // Next-state and handshake decode.
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_in_ready = 1'b0;
    case (r_fsm)
      IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) w_fsm_nxt = RUN;
        else            w_fsm_nxt = IDLE;
      end
      RUN: begin
        if (r_round == 4'd10) w_fsm_nxt = DONE;
        else                  w_fsm_nxt = RUN;
      end
      DONE: begin
        w_in_ready = i_out_ready;
        if (i_out_ready && i_in_valid) w_fsm_nxt = RUN;
        else if (i_out_ready)          w_fsm_nxt = IDLE;
        else                           w_fsm_nxt = DONE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_fsm_nxt  = IDLE;
      w_in_ready = 1'b0;
    end else begin
      w_fsm_nxt  = w_fsm_nxt;
    end
  end

  assign w_accept = w_in_ready & i_in_valid;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Round counter, cipher state and round key; abort wipes key material.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= 4'd0;
      r_state <= 128'h0;
      r_rk    <= 128'h0;
    end else if (w_abort) begin
      r_round <= 4'd0;
      r_state <= 128'h0;
      r_rk    <= 128'h0;
    end else begin
      case (r_fsm)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state <= i_in_pt ^ i_in_key;
            r_rk    <= i_in_key;
            r_round <= 4'd1;
          end
        end
        RUN: begin
          r_state <= w_step;
          r_rk    <= w_nk;
          if (r_round != 4'd10) r_round <= r_round + 4'd1;
        end
        default: r_round <= 4'd0;
      endcase
    end
  end

  // Status outputs registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_fsm_nxt == DONE);
      r_busy      <= (w_fsm_nxt == RUN);
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_ct    = r_state;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 known-answer vectors;
// abort scenario runs only when AES_ABORT_EN is defined.
module tb_aes128_round_ctrl;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_pt;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ct;
  logic         busy;
`ifdef AES_ABORT_EN
  logic         abort;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int edges;
  int busy_cnt;
  int seen_valid;

  aes128_round_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_ABORT_EN
    .i_abort     (abort),
`endif
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_pt     (in_pt),
    .i_in_key    (in_key),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_ct    (out_ct),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tx(input logic [127:0] key, input logic [127:0] pt);
    in_key   = key;
    in_pt    = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; counts edges until out_valid.
  task automatic wait_done(output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 0;
    while (!out_valid && n_edges < 30) begin
      if (busy) n_busy++;
      tick();
      n_edges++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pt     = 128'h0;
    in_key    = 128'h0;
    out_ready = 1'b1;
`ifdef AES_ABORT_EN
    abort     = 1'b0;
`endif
    tick();
    tick();
    chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_out_ct", out_ct, 128'h0);
    chk("rst_busy", {127'h0, busy}, 128'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {127'h0, in_ready}, 128'h1);

    // App. B with immediate consumption
    start_tx(KB, PB);
    chk("b_busy_start", {127'h0, busy}, 128'h1);
    chk("b_in_ready_run", {127'h0, in_ready}, 128'h0);
    wait_done(edges, busy_cnt);
    chk("b_latency", edges, 128'd10);
    chk("b_busy_cycles", busy_cnt, 128'd10);
    chk("b_ct", out_ct, CB);
    chk("b_busy_done", {127'h0, busy}, 128'h0);
    tick();
    chk("b_idle_valid", {127'h0, out_valid}, 128'h0);

    // App. C.1
    start_tx(KC, PC);
    wait_done(edges, busy_cnt);
    chk("c_latency", edges, 128'd10);
    chk("c_ct", out_ct, CC);
    tick();

    // Backpressure: hold result while ignoring new offers
    out_ready = 1'b0;
    start_tx(KB, PB);
    wait_done(edges, busy_cnt);
    chk("bp_latency", edges, 128'd10);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_pt    = PC;
      in_key   = KC;
      #1;
      chk("bp_in_ready", {127'h0, in_ready}, 128'h0);
      tick();
      chk("bp_valid_hold", {127'h0, out_valid}, 128'h1);
      chk("bp_ct_hold", out_ct, CB);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rel", {127'h0, in_ready}, 128'h1);
    chk("bp_ct_taken", out_ct, CB);
    tick();
    chk("bp_valid_drop", {127'h0, out_valid}, 128'h0);
    chk("bp_idle_ready", {127'h0, in_ready}, 128'h1);

    // Back-to-back: second block accepted in the DONE cycle
    start_tx(KB, PB);
    wait_done(edges, busy_cnt);
    chk("bb_first_ct", out_ct, CB);
    in_key   = KC;
    in_pt    = PC;
    in_valid = 1'b1;
    #1;
    chk("bb_in_ready_done", {127'h0, in_ready}, 128'h1);
    tick();
    in_valid = 1'b0;
    chk("bb_accepted_busy", {127'h0, busy}, 128'h1);
    chk("bb_valid_low", {127'h0, out_valid}, 128'h0);
    wait_done(edges, busy_cnt);
    chk("bb_spacing", edges + 1, 128'd11);
    chk("bb_second_ct", out_ct, CC);
    tick();

    // Reset during round 5
    start_tx(KC, PC);
    for (int i = 0; i < 4; i++) tick();
    chk("rr_busy_mid", {127'h0, busy}, 128'h1);
    rst_n = 1'b0;
    #1;
    chk("rr_valid", {127'h0, out_valid}, 128'h0);
    chk("rr_ct", out_ct, 128'h0);
    chk("rr_busy", {127'h0, busy}, 128'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rr_in_ready", {127'h0, in_ready}, 128'h1);
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    chk("rr_no_valid", seen_valid, 128'd0);
    start_tx(KB, PB);
    wait_done(edges, busy_cnt);
    chk("rr_after_latency", edges, 128'd10);
    chk("rr_after_ct", out_ct, CB);
    tick();

`ifdef AES_ABORT_EN
    // Abort during round 3
    start_tx(KB, PB);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_ct_cleared", out_ct, 128'h0);
    chk("ab_busy", {127'h0, busy}, 128'h0);
    chk("ab_valid", {127'h0, out_valid}, 128'h0);
    chk("ab_in_ready", {127'h0, in_ready}, 128'h1);
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    chk("ab_no_valid", seen_valid, 128'd0);
    start_tx(KC, PC);
    wait_done(edges, busy_cnt);
    chk("ab_after_ct", out_ct, CC);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
